// File: rtl/mc_controller.sv
// Multicycle CPU main controller: Moore FSM decoding a 6-bit opcode into datapath controls.
// Optional bne support is compiled in with `define MC_CONTROLLER_BNE_EN.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state_dbg
);

    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11,
        StBneEx   = 4'd12
    } state_e;

    state_e state_q, state_d;

    logic pc_write, branch, op_illegal;
    logic ir_write_raw, mem_write_raw, reg_write_raw;
`ifdef MC_CONTROLLER_BNE_EN
    logic branch_ne;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Every terminal state, and any unused encoding, falls back to FETCH via the default.
    always_comb begin
        state_d       = StFetch;
        iord          = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        pc_write      = 1'b0;
        branch        = 1'b0;
        op_illegal    = 1'b0;
`ifdef MC_CONTROLLER_BNE_EN
        branch_ne     = 1'b0;
`endif
        case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = 2'b01;
                state_d      = StDecode;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                case (op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
`ifdef MC_CONTROLLER_BNE_EN
                    OpBne:      state_d = StBneEx;
`endif
                    default: begin
                        state_d    = StFetch;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            StMemWr: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StRtypeWb;
            end
            StRtypeWb: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBeqEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write_raw = 1'b1;
            end
            StJEx: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_CONTROLLER_BNE_EN
            StBneEx: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch_ne = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Write enables and pc_en are masked while reset is held so nothing commits mid-reset.
    assign ir_write   = ir_write_raw & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign illegal_op = op_illegal & ~reset;
`ifdef MC_CONTROLLER_BNE_EN
    assign pc_en      = (pc_write | (branch & zero) | (branch_ne & ~zero)) & ~reset;
`else
    assign pc_en      = (pc_write | (branch & zero)) & ~reset;
`endif
    assign state_dbg  = state_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL expose: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL expose: op  input  6  opcode from instruction register, stable from DECODE until the return to FETCH.
REQ-004 The block SHALL expose: zero  input  1  ALU zero flag, valid in branch-execute states.
REQ-005 The block SHALL expose outputs (width 1): iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_en, illegal_op.
REQ-006 The block SHALL expose outputs (width 2): alu_src_b, alu_op, pc_src; alu_op feeds the ALU decoder (00 add, 01 sub, 10 funct).
REQ-007 The block SHALL expose: state_dbg  output  4  current state encoding.

Function
REQ-008 The block SHALL be a Moore FSM with a single 4-bit state register; all outputs SHALL be combinational decodes of state, except pc_en and illegal_op.
REQ-009 Encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
REQ-010 Outputs not listed for a state SHALL be 0 in that state.
REQ-011 FETCH SHALL drive ir_write=1, pc_write=1, alu_src_b=01, alu_op=00, pc_src=00, iord=0.
REQ-012 DECODE SHALL drive alu_src_b=11, alu_op=00. MEMADR and ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-013 MEMRD SHALL drive iord=1. MEMWR SHALL drive iord=1, mem_write=1. MEMWB SHALL drive mem_to_reg=1, reg_write=1.
REQ-014 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10. RTYPEWB SHALL drive reg_dst=1, reg_write=1. ADDIWB SHALL drive reg_write=1.
REQ-015 BEQEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, internal branch=1. JEX SHALL drive pc_src=10, internal pc_write=1.
REQ-016 pc_en SHALL equal pc_write OR (branch AND zero), plus the bne term of REQ-027 when that macro is defined.
REQ-017 Transitions SHALL be: FETCH->DECODE; MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX, BNEEX->FETCH.
REQ-018 DECODE SHALL branch on op: 100011 or 101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other value -> FETCH.
REQ-019 MEMADR SHALL go to MEMRD when op=100011, and to MEMWR otherwise.
REQ-020 illegal_op SHALL pulse high for exactly the DECODE cycle in which op is unsupported; the instruction SHALL be retired as a NOP (3 cycles including the next FETCH).
REQ-021 Unused state encodings (13-15) SHALL transition to FETCH on the next edge with all outputs 0.
REQ-022 Instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-023 When reset=1 at a rising clk edge, state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-024 While reset=1, ir_write, mem_write, reg_write, pc_en and illegal_op SHALL be forced to 0 combinationally; other outputs follow state.
REQ-025 The first cycle after reset deasserts SHALL be a full FETCH cycle (ir_write=1, pc_en=1).

Configuration
REQ-026 The macro MC_CONTROLLER_BNE_EN SHALL gate bne support.
REQ-027 With MC_CONTROLLER_BNE_EN defined, DECODE with op=000101 SHALL go to BNEEX, which drives the BEQEX outputs but with internal branch_ne=1 in place of branch, and pc_en SHALL add the term branch_ne AND NOT zero.
REQ-028 Without MC_CONTROLLER_BNE_EN, op=000101 SHALL be illegal (REQ-020), state 12 SHALL be unused (REQ-021), and the branch_ne logic SHALL be absent.

Verification
REQ-029 Reset for 2 cycles, release, op=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in MEMWB; pc_en=1 only in FETCH.
REQ-030 op=000100: zero=1 -> pc_en=1 in BEQEX with pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-031 op=000000 -> alu_op=10 in RTYPEEX, reg_dst=1 and reg_write=1 in RTYPEWB; op=101011 -> mem_write=1 for exactly one cycle with iord=1.
REQ-032 op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; no write enable asserted.
REQ-033 Assert reset during MEMRD of lw -> state 0 next edge, reg_write never asserted; while reset held, pc_en=0 and ir_write=0.
REQ-034 op=000101 with zero=0: with the macro defined -> BNEEX, pc_en=1; without it -> illegal_op=1.
